// File: rtl/multicycle_controller.sv
// Multicycle RISC-V main controller: FSM, ALU decoder and immediate decoder.
// Define MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE until mem_ready.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   state_e     state_q, state_d;
   logic       mem_ok;
   logic       pc_update;
   logic       branch;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] alu_op;

`ifdef MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = S_FETCH;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      alu_op    = 2'b00;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write  = mem_ok;
            pc_update = mem_ok;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            state_d   = mem_ok ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = mem_ok ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            // write strobe held for the whole wait, memory latches on ready
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            state_d   = mem_ok ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // write enables are forced low while reset is held
   assign PCWrite  = ~reset & (pc_update | (branch & Zero));
   assign IRWrite  = ~reset & ir_write;
   assign MemWrite = ~reset & mem_write;
   assign RegWrite = ~reset & reg_write;
   assign state    = state_q;

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: driver queues expected outputs,
// negedge monitor pops and compares.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

`ifdef MEM_WAIT_EN
   localparam logic MR = 1'b1;
`else
   localparam logic MR = 1'b0;
`endif

   // {IRWrite,MemWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB}
   localparam logic [9:0] C_RST  = 10'b0000_10_00_10;
   localparam logic [9:0] C_FET  = 10'b1000_10_00_10;
   localparam logic [9:0] C_DEC  = 10'b0000_00_01_01;
   localparam logic [9:0] C_MADR = 10'b0000_00_10_01;
   localparam logic [9:0] C_MRD  = 10'b0001_00_00_00;
   localparam logic [9:0] C_MWB  = 10'b0010_01_00_00;
   localparam logic [9:0] C_MWR  = 10'b0101_00_00_00;
   localparam logic [9:0] C_EXR  = 10'b0000_00_10_00;
   localparam logic [9:0] C_EXI  = 10'b0000_00_10_01;
   localparam logic [9:0] C_AWB  = 10'b0010_00_00_00;
   localparam logic [9:0] C_JAL  = 10'b0000_00_01_10;
   localparam logic [9:0] C_BEQ  = 10'b0000_00_10_00;

   typedef struct {
      logic [19:0] v;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic done = 1'b0;

   task automatic step(
      input string      nm,
      input logic       rst,
      input logic [6:0] o,
      input logic [2:0] f3,
      input logic       f7,
      input logic       z,
      input logic       mr,
      input logic [3:0] es,
      input logic       epcw,
      input logic [9:0] ec,
      input logic [1:0] ei,
      input logic [2:0] ea
   );
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rst;
      op        = o;
      funct3    = f3;
      funct7b5  = f7;
      Zero      = z;
      mem_ready = mr;
      e.v  = {es, epcw, ec, ei, ea};
      e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic fetch_dec(
      input string      nm,
      input logic [6:0] o,
      input logic [2:0] f3,
      input logic       f7,
      input logic [1:0] ei
   );
      step({nm, "_fetch"}, 0, o, f3, f7, 0, MR, 4'd0, 1, C_FET, ei, 3'b000);
      step({nm, "_dec"}, 0, o, f3, f7, 0, MR, 4'd1, 0, C_DEC, ei, 3'b000);
   endtask

   task automatic rtype(
      input string      nm,
      input logic [6:0] o,
      input logic [2:0] f3,
      input logic       f7,
      input logic [3:0] ex_st,
      input logic [9:0] ex_c,
      input logic [2:0] ea
   );
      fetch_dec(nm, o, f3, f7, 2'b00);
      step({nm, "_ex"}, 0, o, f3, f7, 0, MR, ex_st, 0, ex_c, 2'b00, ea);
      step({nm, "_wb"}, 0, o, f3, f7, 0, MR, 4'd7, 0, C_AWB, 2'b00, 3'b000);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [19:0] got;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s: got %b required %b (state %0d vs %0d)",
                        e.nm, got, e.v, got[19:16], e.v[19:16]);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      if (!done) begin
         $display("FAIL watchdog: time limit reached, errors=%0d", errors);
         $fatal(1, "timeout");
      end
   end

   initial begin : driver
      step("reset", 1, OP_LW, 0, 0, 0, MR, 4'd0, 0, C_RST, 2'b00, 3'b000);

      // lw, mem_ready low in the default build
      fetch_dec("lw", OP_LW, 3'b010, 0, 2'b00);
      step("lw_madr", 0, OP_LW, 3'b010, 0, 0, MR, 4'd2, 0, C_MADR, 2'b00, 3'b000);
      step("lw_mrd", 0, OP_LW, 3'b010, 0, 0, MR, 4'd3, 0, C_MRD, 2'b00, 3'b000);
      step("lw_mwb", 0, OP_LW, 3'b010, 0, 0, MR, 4'd4, 0, C_MWB, 2'b00, 3'b000);

      rtype("sub", OP_R, 3'b000, 1, 4'd6, C_EXR, 3'b001);
      rtype("add", OP_R, 3'b000, 0, 4'd6, C_EXR, 3'b000);
      rtype("and", OP_R, 3'b111, 0, 4'd6, C_EXR, 3'b010);
      rtype("or", OP_R, 3'b110, 0, 4'd6, C_EXR, 3'b011);
      rtype("slt", OP_R, 3'b010, 0, 4'd6, C_EXR, 3'b101);
      rtype("sll", OP_R, 3'b001, 0, 4'd6, C_EXR, 3'b000);
      rtype("addi", OP_I, 3'b000, 1, 4'd8, C_EXI, 3'b000);
      rtype("andi", OP_I, 3'b111, 0, 4'd8, C_EXI, 3'b010);

      fetch_dec("jal", OP_JAL, 0, 0, 2'b11);
      step("jal_jal", 0, OP_JAL, 0, 0, 0, MR, 4'd9, 1, C_JAL, 2'b11, 3'b000);
      step("jal_wb", 0, OP_JAL, 0, 0, 0, MR, 4'd7, 0, C_AWB, 2'b11, 3'b000);

      fetch_dec("beqt", OP_BEQ, 0, 0, 2'b10);
      step("beqt_br", 0, OP_BEQ, 0, 0, 1, MR, 4'd10, 1, C_BEQ, 2'b10, 3'b001);
      fetch_dec("beqn", OP_BEQ, 0, 0, 2'b10);
      step("beqn_br", 0, OP_BEQ, 0, 0, 0, MR, 4'd10, 0, C_BEQ, 2'b10, 3'b001);

      fetch_dec("bad", 7'b0000000, 0, 0, 2'b00);

      fetch_dec("sw", OP_SW, 3'b010, 0, 2'b01);
      step("sw_madr", 0, OP_SW, 3'b010, 0, 0, MR, 4'd2, 0, C_MADR, 2'b01, 3'b000);
      step("sw_mwr", 0, OP_SW, 3'b010, 0, 0, MR, 4'd5, 0, C_MWR, 2'b01, 3'b000);

`ifdef MEM_WAIT_EN
      step("wsw_f0", 0, OP_SW, 0, 0, 0, 0, 4'd0, 0, C_RST, 2'b01, 3'b000);
      step("wsw_f1", 0, OP_SW, 0, 0, 0, 0, 4'd0, 0, C_RST, 2'b01, 3'b000);
      step("wsw_f2", 0, OP_SW, 0, 0, 0, 1, 4'd0, 1, C_FET, 2'b01, 3'b000);
      step("wsw_dec", 0, OP_SW, 0, 0, 0, 0, 4'd1, 0, C_DEC, 2'b01, 3'b000);
      step("wsw_madr", 0, OP_SW, 0, 0, 0, 0, 4'd2, 0, C_MADR, 2'b01, 3'b000);
      for (int i = 0; i < 3; i++)
         step("wsw_mwr_wait", 0, OP_SW, 0, 0, 0, 0, 4'd5, 0, C_MWR, 2'b01, 3'b000);
      step("wsw_mwr_go", 0, OP_SW, 0, 0, 0, 1, 4'd5, 0, C_MWR, 2'b01, 3'b000);
`endif

      // reset lands just after the edge that entered MEMWRITE
      fetch_dec("swr", OP_SW, 3'b010, 0, 2'b01);
      step("swr_madr", 0, OP_SW, 3'b010, 0, 0, MR, 4'd2, 0, C_MADR, 2'b01, 3'b000);
      step("swr_async", 1, OP_SW, 3'b010, 0, 0, MR, 4'd0, 0, C_RST, 2'b01, 3'b000);
      step("swr_hold", 1, OP_SW, 3'b010, 0, 0, MR, 4'd0, 0, C_RST, 2'b01, 3'b000);
      step("swr_rel", 0, OP_SW, 3'b010, 0, 0, MR, 4'd0, 1, C_FET, 2'b01, 3'b000);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
